// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one byte-wide SPI master core among N_REQ requesters,
// driving one active-low slave select per requester that stays low across a whole burst.
module spi_master_arbiter #(
  parameter int N_REQ    = 3,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   last_i,
  input  logic [8*N_REQ-1:0] tx_data_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   rx_valid_o,
  output logic [7:0]         rx_data_o,
  output logic [N_REQ-1:0]   ss_n_o,
  output logic               busy_o,
  output logic [7:0]         spi_din_o,
  output logic               spi_start_o,
  input  logic [7:0]         spi_dout_i,
  input  logic               spi_done_tick_i,
  input  logic               spi_ready_i
);

  localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);
  localparam logic [CW-1:0]    SETUP_LOAD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]    HOLD_LOAD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   last_owner;
  logic [CW-1:0]   count;
  logic            last_byte;
  logic [OW-1:0]   grant_idx;
  logic [OW-1:0]   cand;
  logic            grant_valid;
  logic [7:0]      tx_bytes [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_tx
      assign tx_bytes[gi] = tx_data_i[8*gi +: 8];
    end
  endgenerate

  // Walk the offsets from farthest to nearest so the requester closest after
  // last_owner is the one left standing.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = OW'((int'(last_owner) + k) % N_REQ);
      if (req_i[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= OW'(N_REQ - 1);
      count       <= '0;
      last_byte   <= 1'b0;
      ss_n_o      <= '1;
      busy_o      <= 1'b0;
      spi_start_o <= 1'b0;
      spi_din_o   <= '0;
      ack_o       <= '0;
      rx_valid_o  <= '0;
      rx_data_o   <= '0;
    end else begin
      spi_start_o <= 1'b0;
      ack_o       <= '0;
      rx_valid_o  <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner  <= grant_idx;
            ss_n_o <= ~(ONE_HOT0 << grant_idx);
            busy_o <= 1'b1;
            count  <= SETUP_LOAD;
            // A one-cycle setup is already covered by the cycle spent here.
            state  <= (CS_SETUP == 1) ? START : SETUP;
          end
        end
        SETUP: begin
          if (count <= CNT_ONE) begin
            count <= '0;
            state <= START;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        START: begin
          if (!req_i[owner]) begin
            count <= HOLD_LOAD;
            state <= HOLD;
          end else if (spi_ready_i) begin
            spi_start_o <= 1'b1;
            spi_din_o   <= tx_bytes[owner];
            ack_o       <= ONE_HOT0 << owner;
            last_byte   <= last_i[owner];
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (spi_done_tick_i) begin
            rx_data_o  <= spi_dout_i;
            rx_valid_o <= ONE_HOT0 << owner;
            if (last_byte || !req_i[owner]) begin
              count <= HOLD_LOAD;
              state <= HOLD;
            end else begin
              state <= START;
            end
          end
        end
        HOLD: begin
          if (count == '0) begin
            ss_n_o     <= '1;
            busy_o     <= 1'b0;
            last_owner <= owner;
            state      <= IDLE;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
